// File: rtl/sig_delay_line.sv
// Circular-buffer audio delay line with valid strobes, mute-until-primed and runtime flush.
// Define SIG_DELAY_MIX_EN to output a dry/wet average instead of the pure delayed sample.
module sig_delay_line #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] delay,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  primed
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] FILL_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic {StFill, StRun} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wptr_q;
    logic [ADDR_WIDTH-1:0]   eff_delay;
    logic [ADDR_WIDTH-1:0]   raddr;
    logic [ADDR_WIDTH:0]     fill_q, fill_d;
    logic                    primed_q, primed_d;
    logic                    run_out_q, run_out_d;
    logic                    valid_q;
    logic                    acc;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   wet_q;

    assign acc       = en & in_valid;
    assign eff_delay = (delay == '0) ? ADDR_WIDTH'(1) : delay;
    // D >= 1, so the read slot never aliases the slot being written.
    assign raddr     = wptr_q - eff_delay;

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        primed_d  = primed_q;
        run_out_d = run_out_q;
        if (flush) begin
            state_d  = StFill;
            fill_d   = acc ? FILL_ONE : '0;
            primed_d = 1'b0;
            if (acc) begin
                run_out_d = 1'b0;
            end
        end else if (acc) begin
            // Compare against history before this write: the read slot must already hold data.
            state_d   = ({1'b0, eff_delay} <= fill_q) ? StRun : StFill;
            fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_ONE;
            primed_d  = (state_d == StRun);
            run_out_d = (state_d == StRun);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFill;
            fill_q    <= '0;
            wptr_q    <= '0;
            primed_q  <= 1'b0;
            run_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            primed_q  <= primed_d;
            run_out_q <= run_out_d;
            valid_q   <= acc;
            if (acc) begin
                wptr_q <= wptr_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (acc) begin
            mem[wptr_q] <= in_data;
            wet_q       <= mem[raddr];
        end
    end

`ifdef SIG_DELAY_MIX_EN
    logic [DATA_WIDTH-1:0] dry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dry_q <= '0;
        end else if (acc) begin
            dry_q <= in_data;
        end
    end

    assign out_data = run_out_q
                    ? DATA_WIDTH'(({1'b0, dry_q} + {1'b0, wet_q}) >> 1)
                    : dry_q;
`else
    assign out_data = run_out_q ? wet_q : '0;
`endif

    assign out_valid = valid_q;
    assign primed    = primed_q;

endmodule

// File: tb/tb_sig_delay_line.sv
// Directed-vector bench for sig_delay_line (DATA_WIDTH=8, ADDR_WIDTH=4).
module tb_sig_delay_line;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] delay = 4'd0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       primed;

    int n_checks = 0;
    int n_bad = 0;

    sig_delay_line #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .delay    (delay),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .primed   (primed)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One accepted sample; checks the response one cycle later.
    task automatic send(input logic [7:0] d, input logic fl, input logic [7:0] exp_data,
                        input logic exp_primed);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("out_data", {24'd0, out_data}, {24'd0, exp_data});
        check_eq("primed", {31'd0, primed}, {31'd0, exp_primed});
    endtask

    task automatic idle(input logic fl, input logic en_v, input logic vld);
        @(negedge clk);
        flush    = fl;
        en       = en_v;
        in_valid = vld;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        en       = 1'b1;
        in_valid = 1'b0;
        check_eq("idle_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
        check_eq("rst_primed", {31'd0, primed}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef SIG_DELAY_MIX_EN
        delay = 4'd1;
        send(8'd100, 1'b0, 8'd100, 1'b0);
        send(8'd200, 1'b0, 8'd150, 1'b1);
`else
        // Basic: delay 3, samples 1..8
        delay = 4'd3;
        for (int k = 1; k <= 8; k++) begin
            send(8'(k), 1'b0, (k >= 4) ? 8'(k - 3) : 8'd0, k >= 4);
        end

        // Gapped valid, delay 2
        do_reset();
        delay = 4'd2;
        send(8'd10, 1'b0, 8'd0, 1'b0);
        idle(1'b0, 1'b1, 1'b0);
        send(8'd20, 1'b0, 8'd0, 1'b0);
        idle(1'b0, 1'b1, 1'b0);
        send(8'd30, 1'b0, 8'd10, 1'b1);
        idle(1'b0, 1'b1, 1'b0);
        send(8'd40, 1'b0, 8'd20, 1'b1);

        // Wrap-around over two pointer wraps, delay 5
        do_reset();
        delay = 4'd5;
        for (int n = 0; n < 40; n++) begin
            send(8'(n), 1'b0, (n >= 5) ? 8'(n - 5) : 8'd0, n >= 5);
        end

        // Delay change
        do_reset();
        delay = 4'd2;
        send(8'd1, 1'b0, 8'd0, 1'b0);
        send(8'd2, 1'b0, 8'd0, 1'b0);
        send(8'd3, 1'b0, 8'd1, 1'b1);
        send(8'd4, 1'b0, 8'd2, 1'b1);
        delay = 4'd10;
        for (int k = 5; k <= 10; k++) begin
            send(8'(k), 1'b0, 8'd0, 1'b0);
        end
        send(8'd11, 1'b0, 8'd1, 1'b1);
        send(8'd12, 1'b0, 8'd2, 1'b1);
        delay = 4'd0;
        send(8'd13, 1'b0, 8'd12, 1'b1);

        // Flush with simultaneous accept, delay 3
        delay = 4'd3;
        send(8'd14, 1'b0, 8'd11, 1'b1);
        send(8'd15, 1'b1, 8'd0, 1'b0);
        send(8'd16, 1'b0, 8'd0, 1'b0);
        send(8'd17, 1'b0, 8'd0, 1'b0);
        send(8'd18, 1'b0, 8'd15, 1'b1);
        send(8'd19, 1'b0, 8'd16, 1'b1);

        // Flush alone: output data holds, primed drops
        idle(1'b1, 1'b1, 1'b0);
        check_eq("flush_hold_data", {24'd0, out_data}, 32'd16);
        check_eq("flush_primed", {31'd0, primed}, 32'd0);
        send(8'd20, 1'b0, 8'd0, 1'b0);

        // en low with in_valid high: nothing accepted
        idle(1'b0, 1'b0, 1'b1);
        send(8'd21, 1'b0, 8'd0, 1'b0);
        send(8'd22, 1'b0, 8'd0, 1'b0);
        send(8'd23, 1'b0, 8'd20, 1'b1);

        // Async reset between edges
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_out_data", {24'd0, out_data}, 32'd0);
        check_eq("arst_primed", {31'd0, primed}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
